// File: rtl/stb_pkg.sv
// Shared types and helpers for the store buffer.
// The struct fixes the width of each resident entry, so the store_buffer
// parameters ADDR_W/DATA_W must stay equal to STB_ADDR_W/STB_DATA_W.
package stb_pkg;

    localparam int STB_ADDR_W = 64;
    localparam int STB_DATA_W = 64;

    // One pending doubleword store.
    typedef struct packed {
        logic [STB_ADDR_W-1:0] addr;
        logic [STB_DATA_W-1:0] data;
    } stb_entry_t;

    // Width of head/tail pointers; at least one bit.
    function automatic int stb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stb_match.sv
// Youngest-match search over the resident store entries.
// Walks the ring from head (oldest) towards tail (youngest). A later match
// overwrites an earlier one, so the reported index is the youngest store
// to the load address.
module stb_match
    import stb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = STB_ADDR_W,
    localparam int PTR_W = stb_ptr_w(DEPTH)
) (
    input  logic [ADDR_W-1:0] addrs_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PTR_W-1:0]  head_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              hit_o,
    output logic [PTR_W-1:0]  hit_idx_o
);

    logic [PTR_W-1:0] idx;

    // Oldest-to-youngest scan; the last match seen is the youngest.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (addrs_i[idx] == ld_addr_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM register and the data memory.
// Stores retire into a circular FIFO and drain to memory whenever the single
// memory port is not needed by a load. Optional macro STB_FORWARD_EN lets
// loads take data from the youngest matching resident store; without it a
// matching load stalls until the matching stores have drained.
//
// Store handshake: a store transfers on a rising edge where st_valid and
// st_ready are both high; st_valid does not wait for st_ready, and the
// request must be held stable while st_valid is high and st_ready is low.
module store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = STB_ADDR_W,
    parameter int DATA_W = STB_DATA_W,
    localparam int PTR_W = stb_ptr_w(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    input  logic              drain_req,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    stb_entry_t        ent_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DEPTH-1:0]  valid_mask;
    logic [PTR_W-1:0]  age;
    logic              full, push, pop, hit;
    logic [PTR_W-1:0]  hit_idx;

    // Entry i is resident when its distance from head is below the count.
    always_comb begin
        age        = '0;
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age           = PTR_W'(i) - head_q;
            valid_mask[i] = ({1'b0, age} < count_q);
            ent_addr[i]   = ent_q[i].addr;
        end
    end

    stb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .addrs_i   (ent_addr),
        .valid_i   (valid_mask),
        .head_i    (head_q),
        .ld_addr_i (ld_addr),
        .hit_o     (hit),
        .hit_idx_o (hit_idx)
    );

    // Acceptance and load stall; a full buffer never bypasses a new store.
    always_comb begin
        full     = (count_q == FULL_CNT);
        st_ready = !full && !drain_req;
        push     = st_valid && st_ready;
`ifdef STB_FORWARD_EN
        ld_stall = ld_valid && full;
`else
        ld_stall = ld_valid && (full || hit);
`endif
        empty    = (count_q == '0);
        count    = count_q;
    end

    // Memory port arbitration: full/stalled -> drain, load, drain, idle.
    always_comb begin
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        ld_data     = '0;
        if (full || ld_stall) begin
            mem_write   = 1'b1;
            mem_address = ent_q[head_q].addr;
            mem_data_in = ent_q[head_q].data;
        end else if (ld_valid) begin
            mem_read    = 1'b1;
            mem_address = ld_addr;
`ifdef STB_FORWARD_EN
            ld_data     = hit ? ent_q[hit_idx].data : mem_data_out;
`else
            ld_data     = mem_data_out;
`endif
        end else if (count_q != '0) begin
            mem_write   = 1'b1;
            mem_address = ent_q[head_q].addr;
            mem_data_in = ent_q[head_q].data;
        end
        pop = mem_write;
    end

    // Pointer and occupancy update; push and pop together keep the count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every resident store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as resident.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[tail_q].addr <= st_addr;
            ent_q[tail_q].data <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data memory.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [63:0] ld_addr;
    logic [63:0] ld_data;
    logic        ld_stall;
    logic        drain_req;
    logic        empty;
    logic [2:0]  count;
    logic [63:0] mem_address;
    logic [63:0] mem_data_in;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_data_out;

    int checks   = 0;
    int failures = 0;

    logic [63:0]  mem [128];
    logic [127:0] exp_q [$];
    logic [127:0] front;

    store_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_stall     (ld_stall),
        .drain_req    (drain_req),
        .empty        (empty),
        .count        (count),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_data_out (mem_data_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory initial image: every word is tagged with its own address.
    function automatic logic [63:0] init_val(input int a);
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    // Data memory: combinational read, write on the rising edge.
    assign mem_data_out = mem[int'(mem_address % 64'd128)];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_write) mem[int'(mem_address % 64'd128)] <= mem_data_in;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_drain(input string tag);
        front = exp_q.pop_front();
        chk({tag, "_we"},   64'(mem_write), 64'd1);
        chk({tag, "_addr"}, mem_address,    front[127:64]);
        chk({tag, "_data"}, mem_data_in,    front[63:0]);
    endtask

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; drain_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_empty",    64'(empty),    64'd1);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_mem_write",64'(mem_write),64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_ld_stall", 64'(ld_stall), 64'd0);
        chk("rst_ld_data",  ld_data,       64'd0);
        reset = 1'b0;
        tick();

        // Three stores held resident by load traffic, then reset mid-flight.
        ld_valid = 1'b1; ld_addr = 64'd99;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 64'(5 + i); st_data = 64'(16'h55 + i);
            #1;
            if (i == 0) begin
                chk("a_ld_read",  64'(mem_read),  64'd1);
                chk("a_ld_addr",  mem_address,    64'd99);
                chk("a_ld_data",  ld_data,        init_val(99));
                chk("a_no_write", 64'(mem_write), 64'd0);
            end
            tick();
        end
        st_valid = 1'b0;
        #1;
        chk("a_count3",   64'(count),     64'd3);
        chk("a_held",     64'(mem_write), 64'd0);
        ld_valid = 1'b0; reset = 1'b1;
        #1;
        chk("a_rst_count", 64'(count),     64'd0);
        chk("a_rst_empty", 64'(empty),     64'd1);
        chk("a_rst_we",    64'(mem_write), 64'd0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("a_mem5", mem[5], init_val(5));
        chk("a_mem6", mem[6], init_val(6));
        chk("a_mem7", mem[7], init_val(7));

        // Single store drains on the cycle after it is accepted.
        st_valid = 1'b1; st_addr = 64'd10; st_data = 64'h1111;
        #1;
        chk("b_idle_we",   64'(mem_write), 64'd0);
        chk("b_idle_addr", mem_address,    64'd0);
        tick();
        st_valid = 1'b0;
        #1;
        chk("b_we",    64'(mem_write), 64'd1);
        chk("b_addr",  mem_address,    64'd10);
        chk("b_data",  mem_data_in,    64'h1111);
        chk("b_count", 64'(count),     64'd1);
        tick();
        chk("b_mem10", mem[10], 64'h1111);
        chk("b_empty", 64'(empty), 64'd1);

        // Two stores to the same address, then a load to it.
        ld_valid = 1'b1; ld_addr = 64'd99;
        st_valid = 1'b1; st_addr = 64'd20; st_data = 64'hA;
        tick();
        st_data = 64'hB;
        tick();
        st_valid = 1'b0; ld_addr = 64'd20;
        #1;
        chk("c_count2", 64'(count), 64'd2);
`ifdef STB_FORWARD_EN
        chk("c_fwd_stall", 64'(ld_stall), 64'd0);
        chk("c_fwd_data",  ld_data,       64'hB);
        chk("c_fwd_read",  64'(mem_read), 64'd1);
        chk("c_fwd_we",    64'(mem_write),64'd0);
        ld_valid = 1'b0;
        tick(); tick();
`else
        chk("c_stall1",  64'(ld_stall),  64'd1);
        chk("c_we1",     64'(mem_write), 64'd1);
        chk("c_data1",   mem_data_in,    64'hA);
        tick();
        chk("c_stall2",  64'(ld_stall),  64'd1);
        chk("c_data2",   mem_data_in,    64'hB);
        tick();
        chk("c_stall3",  64'(ld_stall),  64'd0);
        chk("c_read3",   64'(mem_read),  64'd1);
        chk("c_ld_data", ld_data,        64'hB);
        ld_valid = 1'b0;
`endif
        #1;
        chk("c_empty", 64'(empty), 64'd1);
        chk("c_mem20", mem[20], 64'hB);

        // Fill to DEPTH under a non-matching load: full rule forces a drain.
        ld_valid = 1'b1; ld_addr = 64'd99;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 64'(30 + i); st_data = 64'(12'h300 + i);
            if (i > 0) exp_q.push_back({64'(30 + i), 64'(12'h300 + i)});
            tick();
        end
        st_addr = 64'd34; st_data = 64'h3FF;
        #1;
        chk("d_count4",   64'(count),     64'd4);
        chk("d_st_ready", 64'(st_ready),  64'd0);
        chk("d_stall",    64'(ld_stall),  64'd1);
        chk("d_we",       64'(mem_write), 64'd1);
        chk("d_read",     64'(mem_read),  64'd0);
        chk("d_addr",     mem_address,    64'd30);
        tick();
        st_valid = 1'b0;
        #1;
        chk("d_count3",   64'(count),     64'd3);
        chk("d_ready3",   64'(st_ready),  64'd1);
        chk("d_stall0",   64'(ld_stall),  64'd0);
        chk("d_read1",    64'(mem_read),  64'd1);
        chk("d_ld_addr",  mem_address,    64'd99);
        chk("d_ld_data",  ld_data,        init_val(99));
        chk("d_mem30",    mem[30],        64'h300);

        // Simultaneous push and pop at count 2, wrapping the pointers.
        ld_valid = 1'b0;
        #1;
        chk_drain("e_pre");
        tick();
        for (int k = 0; k < 6; k++) begin
            st_valid = 1'b1; st_addr = 64'(40 + k); st_data = 64'(12'h400 + k);
            exp_q.push_back({64'(40 + k), 64'(12'h400 + k)});
            #1;
            chk("e_count2", 64'(count), 64'd2);
            chk_drain("e_pp");
            tick();
        end
        st_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            #1;
            chk_drain("e_tail");
            tick();
        end
        chk("e_empty", 64'(empty), 64'd1);
        chk("e_mem45", mem[45], 64'h405);

        // Fence with three resident stores and a store still offered.
        ld_valid = 1'b1; ld_addr = 64'd99;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 64'(50 + i); st_data = 64'(12'h500 + i);
            exp_q.push_back({64'(50 + i), 64'(12'h500 + i)});
            tick();
        end
        ld_valid = 1'b0; drain_req = 1'b1;
        st_addr = 64'd53; st_data = 64'h5FF;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("f_st_ready", 64'(st_ready), 64'd0);
            chk_drain("f_drain");
            tick();
        end
        chk("f_empty", 64'(empty), 64'd1);
        chk("f_count", 64'(count), 64'd0);
        chk("f_mem50", mem[50], 64'h500);
        chk("f_mem51", mem[51], 64'h501);
        chk("f_mem52", mem[52], 64'h502);
        chk("f_mem53", mem[53], init_val(53));
        drain_req = 1'b0; st_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of pending doubleword stores placed directly upstream of the data memory, between the EX/MEM pipeline register and the memory block.
- Decouples store retirement from the single shared memory port: stores retire into the buffer, then drain to memory in cycles when no load needs the port.
- Loads check the buffer and receive the youngest matching store data, or go straight to memory.
- Drives the memory's address, data_in, MemWrite and MemRead inputs and consumes its data_out.

Parameters:
- DEPTH, 4, number of store entries; power of 2, ≥2.
- ADDR_W, 64, address width (doubleword index, same as the memory address).
- DATA_W, 64, store/load data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from the MEM stage.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data (signed doubleword).
- st_ready  out  1  buffer accepts the store this cycle.
- ld_valid  in  1  load request from the MEM stage.
- ld_addr  in  ADDR_W  load address.
- ld_data  out  DATA_W  load result (forwarded or from memory).
- ld_stall  out  1  load not serviced this cycle; the pipeline must hold it.
- drain_req  in  1  fence: block new stores and drain everything.
- empty  out  1  no entries resident.
- count  out  $clog2(DEPTH)+1  occupancy.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_data_out  in  DATA_W  from memory data_out.

Behaviour:
- Storage and reset
  - Circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
  - On reset: head=tail=count=0. All buffered stores are discarded and never written, including on reset mid-drain.
  - Reset values: st_ready=1, empty=1, mem_write=0, mem_read=0, ld_stall=0, ld_data=0 (when ld_valid=0).
- Push
  - st_ready = (count<DEPTH) && !drain_req. There is no same-cycle bypass when full.
  - When st_valid && st_ready, the entry {st_addr, st_data} is written at tail on the clock edge and tail increments.
- Port arbitration (combinational, each cycle)
  - Full: if count==DEPTH, drain wins. mem_write=1 and ld_stall=ld_valid.
  - Load: else if ld_valid && !ld_stall, mem_read=1, mem_address=ld_addr, mem_write=0.
  - Drain: else if count>0, mem_write=1, mem_address/mem_data_in = head entry. The memory writes on that edge, then head increments.
  - Idle: otherwise mem_write=0, mem_read=0, mem_address=0, mem_data_in=0.
- Load lookup
  - All resident entries are compared with ld_addr; the youngest match (closest to tail) wins.
  - A store presented in the same cycle is not yet resident and is not visible to the load.
- Counting
  - Simultaneous push and pop leaves count unchanged. Push alone increments count; pop alone decrements it.
  - empty = (count==0).
- Drain request
  - drain_req blocks pushes and has no other effect.
  - Upstream holds drain_req until empty=1.
  - Loads keep their port priority while draining, except under the full rule.
- Latency
  - A store is visible in memory ≥1 cycle after acceptance: the drain cycle is the earliest cycle after the push edge.
  - A load result is combinational in the same cycle.

Optional Feature:
- Macro: STB_FORWARD_EN.
- Defined:
  - On a hit, ld_data is the youngest matching entry data.
  - On a miss, ld_data is mem_data_out.
  - ld_stall is asserted only under the full rule.
- Undefined:
  - No forwarding. ld_stall=1 whenever ld_valid and any resident entry matches ld_addr.
  - During such a stall the port is given to drain, exactly as in the full case.
  - The load proceeds to memory once no match remains.
  - ld_data is always mem_data_out when serviced.

Decomposition:
- Package stb_pkg holds:
  - ADDR_W/DATA_W defaults.
  - The stb_entry_t struct {addr, data}.
  - The pointer-width function/localparam.
- One sub-module, stb_match: a parameterised youngest-match priority search over DEPTH entries. It takes the entries, valid mask, head and ld_addr, and outputs hit and hit_idx.

Test Plan:
- Reset with 3 entries resident → count=0, empty=1, mem_write=0; addresses 5/6/7 retain their old memory values.
- Push store (10, 0x1111), no loads → next cycle mem_write=1, mem_address=10; memory[10]=0x1111; empty=1 after that edge.
- Push (20, 0xA) then (20, 0xB); ld_addr=20 while both are resident. With STB_FORWARD_EN → ld_data=0xB, ld_stall=0. Without → ld_stall=1 until both are drained, then ld_data=0xB.
- Fill 4 entries with ld_valid held high on address 99 (no match) → st_ready=0 and ld_stall=1 for one cycle, drain of head, then count=3, st_ready=1, load serviced.
- Push and pop in the same cycle at count=2 → count stays 2; pointers wrap correctly across 6 consecutive pushes and drains.
- Assert drain_req with 3 entries resident and st_valid=1 → st_ready=0; memory is written in FIFO order over 3 load-free cycles, then empty=1.
